// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: loads a seed into an 8-bit Fibonacci-style LFSR, advances it a
// counted number of steps, then holds the final value with a done flag until
// the next start request.
module lfsr_seq_ctrl #(
  parameter int unsigned    W    = 8,
  parameter int unsigned    CW   = 8,
  parameter logic [W-1:0]   TAPS = W'(8'hB8)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  sw_in,
  input  logic [CW-1:0] seq_num,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [W-1:0]  lfsr_q,
  output logic [CW-1:0] steps_left
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    lfsr_d;
  logic [CW-1:0]   steps_d;
  logic [W-1:0]    seed_guarded;
  logic [W-1:0]    lfsr_step;

  // All-zero seed would lock the LFSR at zero, so substitute 1.
  assign seed_guarded = (sw_in == '0) ? W'(1) : sw_in;
  assign lfsr_step    = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      lfsr_q     <= '0;
      steps_left <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      steps_left <= steps_d;
    end
  end

  // Next-state and datapath update; DONE accepts start exactly like IDLE.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    steps_d = steps_left;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          lfsr_d  = seed_guarded;
          steps_d = seq_num;
          state_d = (seq_num == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        lfsr_d  = lfsr_step;
        steps_d = steps_left - CW'(1);
        // Exiting at 1 keeps the counter from wrapping below zero.
        if (steps_left == CW'(1)) begin
          state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy   = (state_q == StRun);
    done   = (state_q == StDone);
    result = lfsr_q;
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl: reset, single/multi-step runs, restart from
// DONE, zero-step runs, held start, ignored inputs during a long run and reset
// abort mid-run.
module tb_lfsr_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] sw_in;
  logic [7:0] seq_num;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] lfsr_q;
  logic [7:0] steps_left;

  int n_checks;
  int n_pass;

  lfsr_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sw_in      (sw_in),
    .seq_num    (seq_num),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .lfsr_q     (lfsr_q),
    .steps_left (steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: guarded seed advanced n times.
  function automatic logic [7:0] lfsr_ref(input logic [7:0] seed, input int n);
    logic [7:0] q;
    q = (seed == 8'h00) ? 8'h01 : seed;
    for (int i = 0; i < n; i++) q = {q[6:0], ^(q & 8'hB8)};
    return q;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    sw_in   = 8'hFF;
    seq_num = 8'h07;
    #12;
    n_checks++;
    if ({busy, done, result, lfsr_q, steps_left} !== 26'd0)
      $display("FAIL reset_hold got busy=%b done=%b result=%h lfsr=%h steps=%h exp all 0",
               busy, done, result, lfsr_q, steps_left);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({busy, done, result, lfsr_q, steps_left} !== 26'd0)
        $display("FAIL reset_idle[%0d] got busy=%b done=%b lfsr=%h steps=%h exp all 0",
                 i, busy, done, lfsr_q, steps_left);
      else n_pass++;
    end
  endtask

  task automatic test_single_step();
    sw_in   = 8'h03;
    seq_num = 8'd1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, done, lfsr_q, steps_left} !== {1'b1, 1'b0, 8'h03, 8'd1})
      $display("FAIL single_run got busy=%b done=%b lfsr=%h steps=%0d exp 1 0 03 1",
               busy, done, lfsr_q, steps_left);
    else n_pass++;
    tick();
    n_checks++;
    if ({busy, done, result, steps_left} !== {1'b0, 1'b1, 8'h06, 8'd0})
      $display("FAIL single_done got busy=%b done=%b result=%h steps=%0d exp 0 1 06 0",
               busy, done, result, steps_left);
    else n_pass++;
  endtask

  task automatic test_three_step();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h23; exp_seq[2] = 8'h47; exp_seq[3] = 8'h8E;
    sw_in   = 8'h11;
    seq_num = 8'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (lfsr_q !== exp_seq[k] || done !== (k == 3) || busy !== (k != 3))
        $display("FAIL three_step[%0d] got lfsr=%h done=%b busy=%b exp lfsr=%h done=%b",
                 k, lfsr_q, done, busy, exp_seq[k], (k == 3));
      else n_pass++;
      if (k != 3) tick();
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (done !== 1'b1 || result !== 8'h8E)
        $display("FAIL three_hold[%0d] got done=%b result=%h exp 1 8e", i, done, result);
      else n_pass++;
    end
  endtask

  task automatic test_restart_zero_seed();
    sw_in   = 8'h30;
    seq_num = 8'd2;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_checks++;
    if (done !== 1'b1 || result !== 8'hC1)
      $display("FAIL restart_first got done=%b result=%h exp 1 c1", done, result);
    else n_pass++;
    sw_in   = 8'h00;
    seq_num = 8'd1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({done, busy, lfsr_q} !== {1'b0, 1'b1, 8'h01})
      $display("FAIL restart_drop got done=%b busy=%b lfsr=%h exp 0 1 01", done, busy, lfsr_q);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b1 || result !== 8'h02)
      $display("FAIL restart_guard got done=%b result=%h exp 1 02", done, result);
    else n_pass++;
  endtask

  task automatic test_zero_steps();
    do_reset();
    sw_in   = 8'h5A;
    seq_num = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, done, result, steps_left} !== {1'b0, 1'b1, 8'h5A, 8'd0})
      $display("FAIL zero_steps got busy=%b done=%b result=%h steps=%0d exp 0 1 5a 0",
               busy, done, result, steps_left);
    else n_pass++;
    // From DONE with N=0: done stays high and result takes the new seed.
    sw_in = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, done, result} !== {1'b0, 1'b1, 8'h3C})
      $display("FAIL zero_redo got busy=%b done=%b result=%h exp 0 1 3c", busy, done, result);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_done;
    exp_done = 4'b1010;  // index k: done after edge E0+k
    sw_in   = 8'h03;
    seq_num = 8'd1;
    start   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (done !== exp_done[k] || (done && result !== 8'h06))
        $display("FAIL back_to_back[%0d] got done=%b result=%h exp done=%b result=06",
                 k, done, result, exp_done[k]);
      else n_pass++;
    end
    start = 1'b0;
  endtask

  task automatic test_long_run();
    logic [7:0] exp_final;
    exp_final = lfsr_ref(8'hA5, 200);
    sw_in   = 8'hA5;
    seq_num = 8'd200;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 200; k++) begin
      if (k == 49) start = 1'b1;
      if (k == 50) start = 1'b0;
      sw_in   = ~sw_in;
      seq_num = seq_num + 8'd7;
      tick();
      if (k == 100) begin
        n_checks++;
        if (lfsr_q !== lfsr_ref(8'hA5, 100) || steps_left !== 8'd100 || busy !== 1'b1)
          $display("FAIL long_mid got lfsr=%h steps=%0d busy=%b exp %h 100 1",
                   lfsr_q, steps_left, busy, lfsr_ref(8'hA5, 100));
        else n_pass++;
      end
      if (k == 199) begin
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || steps_left !== 8'd1)
          $display("FAIL long_early got done=%b busy=%b steps=%0d exp 0 1 1",
                   done, busy, steps_left);
        else n_pass++;
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== exp_final)
      $display("FAIL long_done got done=%b busy=%b result=%h exp 1 0 %h",
               done, busy, result, exp_final);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    sw_in   = 8'hA5;
    seq_num = 8'd200;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 100; k++) tick();
    n_checks++;
    if (busy !== 1'b1 || steps_left !== 8'd100)
      $display("FAIL abort_pre got busy=%b steps=%0d exp 1 100", busy, steps_left);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result, lfsr_q, steps_left} !== 26'd0)
      $display("FAIL abort_async got busy=%b done=%b lfsr=%h steps=%0d exp all 0",
               busy, done, lfsr_q, steps_left);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, done, lfsr_q, steps_left} !== 18'd0)
      $display("FAIL abort_idle got busy=%b done=%b lfsr=%h steps=%0d exp all 0",
               busy, done, lfsr_q, steps_left);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    sw_in    = 8'h00;
    seq_num  = 8'h00;
    test_reset();
    test_single_step();
    test_three_step();
    test_restart_zero_seed();
    test_zero_steps();
    test_back_to_back();
    test_long_run();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Sequencing controller for the 8-bit LFSR datapath. It accepts a seed from the switch inputs (`sw_in`) and a step count (`seq_num`). On a `start` request it loads the LFSR, advances it exactly `seq_num` times, then presents and holds the result with a `done` flag. It sits between the board switch/button inputs and the display path, and replaces free-running LFSR operation with a counted, handshaked run.

## Interface
- `W`, 8: LFSR and seed width in bits.
- `CW`, 8: step-count width in bits.
- `TAPS`, 8'hB8: feedback tap mask, W bits. Bit i set means state bit i feeds the XOR.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: run request, level-sampled on the rising edge.
- `sw_in` input W: seed value.
- `seq_num` input CW: number of LFSR steps to perform.
- `busy` output 1: high while stepping (RUN state).
- `done` output 1: high in DONE state; `result` is valid.
- `result` output W: final LFSR state, held while `done` is high.
- `lfsr_q` output W: live LFSR register, for debug.
- `steps_left` output CW: remaining step counter.

## Operation
- Step function: next = {q[W-2:0], ^(q & TAPS)}. This is a shift left with the XOR-reduced feedback bit entering at bit 0.
- Zero-seed guard: a seed of all zeros is loaded as 1 (8'h01), so the register cannot lock up at zero.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE: `busy`=0, `done`=0. If `start`=1 at the clock edge:
  - `lfsr_q` <= guarded seed.
  - `steps_left` <= `seq_num`.
  - Next state is RUN, or DONE directly when `seq_num`=0.
- RUN: on every edge, `lfsr_q` <= next(`lfsr_q`) and `steps_left` <= `steps_left`-1.
  - When `steps_left`=1 at the edge, next state is DONE.
  - `start` is ignored in RUN.
- DONE: `done`=1, `result` = `lfsr_q`, which is frozen. `steps_left`=0.
  - `start`=1 restarts the run exactly as from IDLE, using the current `sw_in` and `seq_num`.
  - Otherwise the FSM stays in DONE indefinitely.
- `result` is a combinational alias of `lfsr_q`. It is only meaningful while `done`=1.
- Inputs are sampled only on the start edge. Changes to `sw_in`/`seq_num` during RUN or DONE have no effect.
- Counter arithmetic is unsigned CW-bit. The counter never decrements below 0, because RUN exits at 1.

## Timing
- Reset values while `rst_n` is low, asynchronous: state=IDLE, `lfsr_q`=0, `steps_left`=0, `busy`=0, `done`=0, `result`=0.
- Reset release: the first edge with `rst_n`=1 is evaluated normally, so `start` may be sampled there.
- Latency: with `start` sampled at edge E0 and `seq_num`=N, `done` rises after edge E0+N. For N=0 it rises after E0.
- `busy` is high after edges E0..E0+N-1 and low from E0+N.
- Restart from DONE: `done` falls after the sampling edge and rises again N edges later. For N=0, `done` stays high and `result` updates to the new seed.
- `start` held high continuously: each arrival in DONE lasts exactly one cycle before restarting.
- Reset asserted mid-RUN aborts the run immediately and clears all outputs. No partial result is retained.
- Maximum run length is 2^CW-1 steps (255 for the defaults).

## Test plan
- Reset with `start`=0 → all outputs 0, state IDLE, and they remain 0 for 5 cycles after release.
- `sw_in`=8'h03, `seq_num`=1, one-cycle `start` → `busy` for 1 cycle, then `done`=1 with `result`=8'h06.
- `sw_in`=8'h11, `seq_num`=3 → `lfsr_q` sequence 8'h23, 8'h47, 8'h8E; `done` after the 3rd step edge; `result`=8'h8E held for 10 cycles.
- `sw_in`=8'h30, `seq_num`=2 → `result`=8'hC1. Then, while in DONE, `sw_in`=8'h00 and `seq_num`=1 with `start` → `done` drops, then `result`=8'h02 via the zero-seed guard.
- `seq_num`=0, `sw_in`=8'h5A → `done` after one edge, `result`=8'h5A, and `busy` never asserts.
- `seq_num`=200: pulse `start` again at step 50 and toggle `sw_in` during the run → ignored, so completion still occurs at step 200. A second run with `rst_n` pulsed low at step 100 → outputs clear immediately and the FSM returns to IDLE.
